// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of it. Frames are sent
// back to back, with no idle gap, for as long as the FIFO holds data.
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int IW  = $clog2(DATA_BITS);

  if (PARITY < 0 || PARITY > 2) begin : gBadParity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wrPtr;
  logic [PW-1:0]        r_rdPtr;
  logic [PW:0]          r_count;

  state_t               r_state;
  logic [CW-1:0]        r_baud;
  logic [IW-1:0]        r_bitIdx;
  logic                 r_stopIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_done;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_tick;
  logic                 w_lastStop;
  logic [DATA_BITS-1:0] w_head;

  // in_ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign in_ready   = (r_count != (PW+1)'(FIFO_DEPTH));
  assign w_push     = in_valid && in_ready;
  assign w_tick     = (r_baud == CW'(DIV - 1));
  assign w_lastStop = (r_state == STOP) && (r_stopIdx == 1'(STOP_BITS - 1));
  assign w_pop      = (r_count != '0) && ((r_state == IDLE) || (w_lastStop && w_tick));
  assign w_head     = r_mem[r_rdPtr];

  assign tx         = r_tx;
  assign done       = r_done;
  assign busy       = (r_state != IDLE) || (r_count != '0);
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // tx is loaded with the next state's line level on each transition; done is
  // raised one cycle early so it is high during the final stop-bit cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bitIdx  <= '0;
      r_stopIdx <= 1'b0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_lastStop && (r_baud == CW'(DIV - 2));
      r_baud <= w_tick ? '0 : r_baud + 1'b1;
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift  <= w_head;
            r_parity <= (PARITY == 2) ? ^w_head : ~^w_head;
            r_bitIdx <= '0;
            r_state  <= START;
            r_tx     <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bitIdx == IW'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                r_state <= PARITY_BIT;
                r_tx    <= r_parity;
              end else begin
                r_state   <= STOP;
                r_stopIdx <= 1'b0;
                r_tx      <= 1'b1;
              end
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
              r_shift  <= r_shift >> 1;
              r_tx     <= r_shift[1];
            end
          end
        end
        PARITY_BIT: begin
          if (w_tick) begin
            r_state   <= STOP;
            r_stopIdx <= 1'b0;
            r_tx      <= 1'b1;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (w_lastStop) begin
              if (w_pop) begin
                r_shift  <= w_head;
                r_parity <= (PARITY == 2) ? ^w_head : ~^w_head;
                r_bitIdx <= '0;
                r_state  <= START;
                r_tx     <= 1'b0;
              end else begin
                r_state <= IDLE;
                r_tx    <= 1'b1;
              end
            end else begin
              r_stopIdx <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances (8N1, 8E2, 7O1, 8N1 with a
// 4-deep FIFO) at DIV = 10, selected through a small output mux.
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic [8:0] inData;
  logic [3:0] vld;
  logic [3:0] rdy, txL, busyL, doneL;
  logic [4:0] cnt0, cnt1, cnt2;
  logic [2:0] cnt3;

  int         sel;
  logic       txS, rdyS, busyS, doneS;
  logic [4:0] cntS;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u8n1 (
    .clk(clk), .reset(reset), .in_data(inData[7:0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .tx(txL[0]), .busy(busyL[0]), .done(doneL[0]),
    .fifo_count(cnt0));

  uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u8e2 (
    .clk(clk), .reset(reset), .in_data(inData[7:0]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .tx(txL[1]), .busy(busyL[1]), .done(doneL[1]),
    .fifo_count(cnt1));

  uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                 .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u7o1 (
    .clk(clk), .reset(reset), .in_data(inData[6:0]), .in_valid(vld[2]),
    .in_ready(rdy[2]), .tx(txL[2]), .busy(busyL[2]), .done(doneL[2]),
    .fifo_count(cnt2));

  uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) uFill (
    .clk(clk), .reset(reset), .in_data(inData[7:0]), .in_valid(vld[3]),
    .in_ready(rdy[3]), .tx(txL[3]), .busy(busyL[3]), .done(doneL[3]),
    .fifo_count(cnt3));

  always #5 clk = ~clk;

  always_comb begin
    txS   = txL[sel];
    rdyS  = rdy[sel];
    busyS = busyL[sel];
    doneS = doneL[sel];
    case (sel)
      0:       cntS = cnt0;
      1:       cntS = cnt1;
      2:       cntS = cnt2;
      default: cntS = {2'b00, cnt3};
    endcase
  end

  // Expected line levels, one entry per bit period: start, data LSB first, parity, stops.
  function automatic logic [15:0] frameBits(input logic [8:0] d, input int nb,
                                            input int par);
    logic [15:0] b;
    logic        p;
    b    = '1;
    b[0] = 1'b0;
    p    = 1'b0;
    for (int i = 0; i < nb; i++) begin
      b[1+i] = d[i];
      p      = p ^ d[i];
    end
    if (par != 0) b[1+nb] = (par == 2) ? p : ~p;
    return b;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 4; s += 3) begin
      sel = s;
      #0;
      checks++; if (txS !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx inst%0d got %b want 1", s, txS); end
      checks++; if (rdyS !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready inst%0d got %b want 1", s, rdyS); end
      checks++; if (busyS !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy inst%0d got %b want 0", s, busyS); end
      checks++; if (doneS !== 1'b0) begin errors++; $display("[TB] FAIL reset_done inst%0d got %b want 0", s, doneS); end
      checks++; if (cntS !== 5'd0) begin errors++; $display("[TB] FAIL reset_count inst%0d got %0d want 0", s, cntS); end
    end
  endtask

  // Single word into an idle instance; checks every cycle of the frame.
  task automatic test_frame(input int s, input logic [8:0] d, input int nb,
                            input int par, input int stops, input string name);
    logic [15:0] fb;
    int          len, f, doneCnt;
    logic        expTx;
    sel = s;
    fb  = frameBits(d, nb, par);
    len = 1 + nb + ((par != 0) ? 1 : 0) + stops;
    f   = len * 10;
    doneCnt = 0;
    @(posedge clk); #1;
    inData = d; vld[s] = 1'b1;
    @(posedge clk); #1;
    vld[s] = 1'b0;
    checks++; if (txS !== 1'b1) begin errors++; $display("[TB] FAIL %s_tx_accept got %b want 1", name, txS); end
    checks++; if (cntS !== 5'd1) begin errors++; $display("[TB] FAIL %s_count_accept got %0d want 1", name, cntS); end
    for (int k = 1; k <= f; k++) begin
      @(posedge clk); #1;
      expTx = fb[(k-1)/10];
      checks++; if (txS !== expTx) begin errors++; $display("[TB] FAIL %s_tx cycle %0d got %b want %b", name, k, txS, expTx); end
      checks++; if (doneS !== (k == f)) begin errors++; $display("[TB] FAIL %s_done cycle %0d got %b want %b", name, k, doneS, (k == f)); end
      if (doneS === 1'b1) doneCnt++;
    end
    @(posedge clk); #1;
    checks++; if (txS !== 1'b1) begin errors++; $display("[TB] FAIL %s_tx_after got %b want 1", name, txS); end
    checks++; if (busyS !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_after got %b want 0", name, busyS); end
    checks++; if (doneS !== 1'b0) begin errors++; $display("[TB] FAIL %s_done_after got %b want 0", name, doneS); end
    checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL %s_done_count got %0d want 1", name, doneCnt); end
  endtask

  // Five words pushed in consecutive cycles into the 4-deep instance, plus a
  // rejected push while full; all frames must run back to back in order.
  task automatic test_back_to_back;
    logic [8:0]  w [5];
    logic [15:0] fb;
    int          wi, mcount, preCount, doneCnt, j;
    logic        preVld, push, pop, expTx, expDone;
    w = '{9'h011, 9'h0C3, 9'h05A, 9'h0FF, 9'h080};
    sel = 3;
    wi = 0; mcount = 0; doneCnt = 0;
    @(posedge clk); #1;
    inData = w[0]; vld[3] = 1'b1;
    for (int k = 0; k <= 505; k++) begin
      preCount = mcount;
      preVld   = vld[3];
      @(posedge clk); #1;
      push   = preVld && (preCount < 4);
      pop    = ((k % 100) == 1) && (preCount > 0);
      mcount = preCount + int'(push) - int'(pop);
      if (push && wi < 5) wi++;
      if (wi < 5) begin
        inData = w[wi]; vld[3] = 1'b1;
      end else if (k >= 4 && k < 8) begin
        inData = 9'h0EE; vld[3] = 1'b1;
      end else begin
        vld[3] = 1'b0;
      end
      if (k >= 1 && k <= 500) begin
        j     = (k - 1) / 100;
        fb    = frameBits(w[j], 8, 0);
        expTx = fb[((k-1) % 100) / 10];
      end else begin
        expTx = 1'b1;
      end
      expDone = ((k % 100) == 0) && (k >= 100) && (k <= 500);
      if (doneS === 1'b1) doneCnt++;
      checks++; if (cntS !== 5'(mcount)) begin errors++; $display("[TB] FAIL b2b_count cycle %0d got %0d want %0d", k, cntS, mcount); end
      checks++; if (rdyS !== (mcount < 4)) begin errors++; $display("[TB] FAIL b2b_ready cycle %0d got %b want %b", k, rdyS, (mcount < 4)); end
      checks++; if (txS !== expTx) begin errors++; $display("[TB] FAIL b2b_tx cycle %0d got %b want %b", k, txS, expTx); end
      checks++; if (doneS !== expDone) begin errors++; $display("[TB] FAIL b2b_done cycle %0d got %b want %b", k, doneS, expDone); end
    end
    checks++; if (busyS !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end got %b want 0", busyS); end
    checks++; if (doneCnt != 5) begin errors++; $display("[TB] FAIL b2b_done_count got %0d want 5", doneCnt); end
  endtask

  // Reset during data bit 3 with two words queued behind the active frame.
  task automatic test_reset_mid_frame;
    sel = 0;
    @(posedge clk); #1;
    inData = 9'h012; vld[0] = 1'b1;
    @(posedge clk); #1;
    inData = 9'h034;
    @(posedge clk); #1;
    inData = 9'h056;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    checks++; if (cntS !== 5'd2) begin errors++; $display("[TB] FAIL midrst_queued got %0d want 2", cntS); end
    for (int k = 3; k <= 45; k++) begin
      @(posedge clk); #1;
      checks++; if (doneS !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done_pre cycle %0d got %b want 0", k, doneS); end
    end
    checks++; if (txS !== 1'b0) begin errors++; $display("[TB] FAIL midrst_bit3 got %b want 0", txS); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (txS !== 1'b1) begin errors++; $display("[TB] FAIL midrst_tx got %b want 1", txS); end
    checks++; if (cntS !== 5'd0) begin errors++; $display("[TB] FAIL midrst_count got %0d want 0", cntS); end
    checks++; if (busyS !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busyS); end
    for (int k = 0; k < 150; k++) begin
      @(posedge clk); #1;
      checks++; if (doneS !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done_post cycle %0d got %b want 0", k, doneS); end
      checks++; if (txS !== 1'b1) begin errors++; $display("[TB] FAIL midrst_idle_tx cycle %0d got %b want 1", k, txS); end
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; inData = '0; vld = '0; sel = 0;
    test_reset();
    test_frame(0, 9'h0A5, 8, 0, 1, "f8n1");
    test_frame(1, 9'h007, 8, 2, 2, "f8e2");
    test_frame(2, 9'h055, 7, 1, 1, "f7o1");
    test_back_to_back();
    test_reset_mid_frame();
    test_frame(0, 9'h03C, 8, 0, 1, "after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
